// File: rtl/mult_div_control.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO ownership, sitting in EX beside the ALU.
// Optional MULT_DIV_EARLY_OUT_EN lets a multiply leave RUN once the remaining multiplier bits are zero.
module mult_div_control #(
  parameter int NB_DATA        = 32,
  parameter int NB_INSTRUCCION = 6,
  parameter int NB_CONT        = 6
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_valid,
  input  logic [NB_INSTRUCCION-1:0] i_inst_funcion,
  input  logic [NB_DATA-1:0]        i_dato_a,
  input  logic [NB_DATA-1:0]        i_dato_b,
  input  logic                      i_flush,
  output logic                      o_stall,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_div_by_zero,
  output logic [NB_DATA-1:0]        o_hi,
  output logic [NB_DATA-1:0]        o_lo,
  output logic [NB_DATA-1:0]        o_mf_dato
);
  localparam logic [NB_INSTRUCCION-1:0] F_MFHI  = NB_INSTRUCCION'(6'b010000);
  localparam logic [NB_INSTRUCCION-1:0] F_MTHI  = NB_INSTRUCCION'(6'b010001);
  localparam logic [NB_INSTRUCCION-1:0] F_MFLO  = NB_INSTRUCCION'(6'b010010);
  localparam logic [NB_INSTRUCCION-1:0] F_MTLO  = NB_INSTRUCCION'(6'b010011);
  localparam logic [NB_INSTRUCCION-1:0] F_MULT  = NB_INSTRUCCION'(6'b011000);
  localparam logic [NB_INSTRUCCION-1:0] F_MULTU = NB_INSTRUCCION'(6'b011001);
  localparam logic [NB_INSTRUCCION-1:0] F_DIV   = NB_INSTRUCCION'(6'b011010);
  localparam logic [NB_INSTRUCCION-1:0] F_DIVU  = NB_INSTRUCCION'(6'b011011);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [NB_CONT-1:0]     cnt_q, cnt_d;
  logic [2*NB_DATA-1:0]   prod_q, prod_d, mcand_q, mcand_d;
  logic [NB_DATA-1:0]     mplier_q, mplier_d, hi_q, hi_d, lo_q, lo_d;
  logic                   is_div_q, is_div_d, neg_p_q, neg_p_d, neg_r_q, neg_r_d;
  logic                   dz_q, dz_d, done_q, done_d, dz_pulse_q, dz_pulse_d;

  logic                   md_op, mf_op, mt_op, op_div, op_signed, accept, q_bit;
  logic [NB_DATA-1:0]     a_abs, b_abs;
  logic [NB_DATA:0]       rem_sh;
  logic [2*NB_DATA-1:0]   prod_fix;

  assign md_op     = (i_inst_funcion == F_MULT) | (i_inst_funcion == F_MULTU) |
                     (i_inst_funcion == F_DIV)  | (i_inst_funcion == F_DIVU);
  assign mf_op     = (i_inst_funcion == F_MFHI) | (i_inst_funcion == F_MFLO);
  assign mt_op     = (i_inst_funcion == F_MTHI) | (i_inst_funcion == F_MTLO);
  assign op_div    = (i_inst_funcion == F_DIV)  | (i_inst_funcion == F_DIVU);
  assign op_signed = (i_inst_funcion == F_MULT) | (i_inst_funcion == F_DIV);
  assign accept    = i_valid & md_op & (state_q == S_IDLE) & ~i_flush;
  assign a_abs     = (op_signed & i_dato_a[NB_DATA-1]) ? -i_dato_a : i_dato_a;
  assign b_abs     = (op_signed & i_dato_b[NB_DATA-1]) ? -i_dato_b : i_dato_b;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prod_d     = prod_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    is_div_d   = is_div_q;
    neg_p_d    = neg_p_q;
    neg_r_d    = neg_r_q;
    dz_d       = dz_q;
    done_d     = 1'b0;
    dz_pulse_d = 1'b0;
    // Divide: mplier_q holds dividend bits shifting out the top and quotient bits shifting in.
    rem_sh     = {prod_q[NB_DATA-1:0], mplier_q[NB_DATA-1]};
    q_bit      = (rem_sh >= {1'b0, mcand_q[NB_DATA-1:0]});
    prod_fix   = neg_p_q ? -prod_q : prod_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_RUN;
          cnt_d    = NB_CONT'(NB_DATA);
          prod_d   = '0;
          is_div_d = op_div;
          neg_p_d  = op_signed & (i_dato_a[NB_DATA-1] ^ i_dato_b[NB_DATA-1]);
          neg_r_d  = op_signed & i_dato_a[NB_DATA-1];
          dz_d     = 1'b0;
          if (op_div) begin
            mcand_d  = {{NB_DATA{1'b0}}, b_abs};
            mplier_d = a_abs;
            if (i_dato_b == '0) begin
              // Divide by zero preloads the final LO/HI pattern so FIX only copies it out.
              state_d  = S_FIX;
              dz_d     = 1'b1;
              neg_p_d  = 1'b0;
              neg_r_d  = 1'b0;
              mplier_d = '1;
              prod_d   = {{NB_DATA{1'b0}}, i_dato_a};
            end
          end else begin
            mcand_d  = {{NB_DATA{1'b0}}, a_abs};
            mplier_d = b_abs;
          end
        end else if (i_valid & ~i_flush & mt_op) begin
          if (i_inst_funcion == F_MTHI) hi_d = i_dato_a;
          else                          lo_d = i_dato_a;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - NB_CONT'(1);
        if (is_div_q) begin
          prod_d   = {{NB_DATA{1'b0}},
                      NB_DATA'(q_bit ? rem_sh - {1'b0, mcand_q[NB_DATA-1:0]} : rem_sh)};
          mplier_d = {mplier_q[NB_DATA-2:0], q_bit};
        end else begin
          // Product accumulates in place, so an early exit needs no realignment in FIX.
          if (mplier_q[0]) prod_d = prod_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
`ifdef MULT_DIV_EARLY_OUT_EN
        if ((cnt_q == NB_CONT'(1)) || (!is_div_q && (mplier_d == '0))) state_d = S_FIX;
`else
        if (cnt_q == NB_CONT'(1)) state_d = S_FIX;
`endif
      end
      S_FIX: begin
        state_d    = S_IDLE;
        done_d     = 1'b1;
        dz_pulse_d = dz_q;
        if (is_div_q) begin
          lo_d = neg_p_q ? -mplier_q : mplier_q;
          hi_d = neg_r_q ? -prod_q[NB_DATA-1:0] : prod_q[NB_DATA-1:0];
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (i_flush) begin
      state_d    = S_IDLE;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      dz_pulse_d = 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      prod_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      neg_p_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prod_q     <= prod_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_div_q   <= is_div_d;
      neg_p_q    <= neg_p_d;
      neg_r_q    <= neg_r_d;
      dz_q       <= dz_d;
      done_q     <= done_d;
      dz_pulse_q <= dz_pulse_d;
    end
  end

  assign o_busy        = (state_q != S_IDLE);
  assign o_stall       = i_valid & (md_op | mf_op | mt_op) & o_busy & ~i_flush;
  assign o_done        = done_q;
  assign o_div_by_zero = dz_pulse_q;
  assign o_hi          = hi_q;
  assign o_lo          = lo_q;
  assign o_mf_dato     = (i_inst_funcion == F_MFHI) ? hi_q : lo_q;
endmodule

// File: tb/tb_mult_div_control.sv
// Bench for mult_div_control: arithmetic reference model checked every cycle plus directed literal checks.
module tb_mult_div_control;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011, F_MULT = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV = 6'b011010, F_DIVU = 6'b011011;
`ifdef MULT_DIV_EARLY_OUT_EN
  localparam int LAT_5X3 = 4, LAT_3X5 = 5, LAT_2X4 = 5, LAT_6X7 = 5;
`else
  localparam int LAT_5X3 = 34, LAT_3X5 = 34, LAT_2X4 = 34, LAT_6X7 = 34;
`endif

  logic        clk = 1'b0, rst_n = 1'b1, valid = 1'b0, flush = 1'b0;
  logic [5:0]  funct = '0;
  logic [31:0] a = '0, b = '0;
  logic        o_stall, o_busy, o_done, o_div_by_zero;
  logic [31:0] o_hi, o_lo, o_mf_dato;
  int          n_tests = 0, n_fail = 0;
  logic        cmp_en = 1'b0;

  mult_div_control dut (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .i_inst_funcion(funct),
    .i_dato_a(a), .i_dato_b(b), .i_flush(flush), .o_stall(o_stall), .o_busy(o_busy),
    .o_done(o_done), .o_div_by_zero(o_div_by_zero), .o_hi(o_hi), .o_lo(o_lo),
    .o_mf_dato(o_mf_dato)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, m_pdz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  int          m_left = 0;

  function automatic logic is_md(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic int run_cycles(input logic [31:0] v);
`ifdef MULT_DIV_EARLY_OUT_EN
    int k = 1;
    for (int i = 0; i < 32; i++) if (v[i]) k = i + 1;
    return k;
`else
    return 32 + 0 * int'(v[0]);
`endif
  endfunction

  task automatic model_result(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                              output logic [31:0] rh, output logic [31:0] rl,
                              output logic dz, output int cycles);
    longint sx, sy, q, r;
    logic [63:0] p;
    dz = 1'b0;
    sx = (f == F_DIV || f == F_MULT) ? longint'($signed(x)) : longint'({32'b0, x});
    sy = (f == F_DIV || f == F_MULT) ? longint'($signed(y)) : longint'({32'b0, y});
    if (f == F_MULT || f == F_MULTU) begin
      p = sx * sy;
      {rh, rl} = p;
      cycles = run_cycles((f == F_MULT && y[31]) ? -y : y) + 1;
    end else if (y == '0) begin
      rl = '1; rh = x; dz = 1'b1; cycles = 1;
    end else begin
      q = sx / sy;
      r = sx % sy;
      rl = q[31:0]; rh = r[31:0]; cycles = 33;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_pdz = 1'b0;
      m_hi = '0; m_lo = '0; m_left = 0;
    end else begin
      m_done = 1'b0; m_dz = 1'b0;
      if (flush) m_busy = 1'b0;
      else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_hi = m_phi; m_lo = m_plo; m_done = 1'b1; m_dz = m_pdz;
        end
      end else if (valid && is_md(funct)) begin
        model_result(funct, a, b, m_phi, m_plo, m_pdz, m_left);
        m_busy = 1'b1;
      end else if (valid && funct == F_MTHI) m_hi = a;
      else if (valid && funct == F_MTLO) m_lo = a;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", o_busy, m_busy);
      check("done", o_done, m_done);
      check("div_by_zero", o_div_by_zero, m_dz);
      check("hi", o_hi, m_hi);
      check("lo", o_lo, m_lo);
      check("stall", o_stall, valid && (is_md(funct) || funct == F_MFHI || funct == F_MFLO ||
                               funct == F_MTHI || funct == F_MTLO) && m_busy && !flush);
      check("mf_dato", o_mf_dato, (funct == F_MFHI) ? m_hi : m_lo);
    end
  end

  // ---------------- drivers ----------------
  task automatic do_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                       output int lat);
    @(posedge clk); #1;
    funct = f; a = x; b = y; valid = 1'b1; lat = 0;
    do begin
      @(posedge clk); lat++; #1 valid = 1'b0;
      @(negedge clk);
    end while (!o_done && lat < 100);
    if (!o_done) check("op_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); n++; #1 valid = 1'b0;
      @(negedge clk);
    end while (!o_done && n < 100);
    if (!o_done) check("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic hold_until_unstalled(input logic [5:0] f, input logic [31:0] x,
                                      input logic [31:0] y, output int n);
    @(posedge clk); #1 funct = f; a = x; b = y; valid = 1'b1; n = 1;
    @(negedge clk);
    check("stall_first", o_stall, 1'b1);
    while (o_stall && n < 100) begin
      @(posedge clk); #1 n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, n;
    logic seen;
    logic [5:0]  tf[6] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_DIV, F_MULT};
    logic [31:0] ta[6] = '{32'h12345678, 32'h12345678, 32'd100, 32'hFFFFFFFF, 32'hFFFFFF9C, 32'h80000000};
    logic [31:0] tb[6] = '{32'h9ABCDEF0, 32'h9ABCDEF0, 32'hFFFFFFF9, 32'd3, 32'd7, 32'h80000000};
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hi", o_hi, 0); check("rst_lo", o_lo, 0);
    check("rst_busy", o_busy, 0); check("rst_done", o_done, 0); check("rst_dz", o_div_by_zero, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    do_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    check("multu_lat", lat, 34); check("multu_hi", o_hi, 32'hFFFFFFFE); check("multu_lo", o_lo, 32'h1);
    do_op(F_MULT, 32'hFFFFFFFD, 32'd7, lat);
    check("mult_neg_hi", o_hi, 32'hFFFFFFFF); check("mult_neg_lo", o_lo, 32'hFFFFFFEB);
    do_op(F_DIV, 32'hFFFFFFF9, 32'd2, lat);
    check("div_neg_lo", o_lo, 32'hFFFFFFFD); check("div_neg_hi", o_hi, 32'hFFFFFFFF);
    check("div_lat", lat, 34);
    do_op(F_DIVU, 32'd7, 32'd0, lat);
    check("dz_lat", lat, 2); check("dz_lo", o_lo, 32'hFFFFFFFF); check("dz_hi", o_hi, 32'd7);
    check("dz_flag", o_div_by_zero, 1'b1);
    do_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, lat);
    check("div_ovf_lo", o_lo, 32'h80000000); check("div_ovf_hi", o_hi, 32'h0);
    do_op(F_MULTU, 32'd5, 32'd3, lat);
    check("early_lat", lat, LAT_5X3); check("early_lo", o_lo, 32'd15);

    for (int i = 0; i < 6; i++) do_op(tf[i], ta[i], tb[i], lat);
    check("tbl_last_hi", o_hi, 32'h40000000); check("tbl_last_lo", o_lo, 32'h0);

    // mflo held behind an in-flight multiply
    @(posedge clk); #1 funct = F_MULT; a = 32'd3; b = 32'd5; valid = 1'b1;
    hold_until_unstalled(F_MFLO, 32'd0, 32'd0, n);
    check("mf_wait", n, LAT_3X5); check("mf_value", o_mf_dato, 32'd15); check("mf_done", o_done, 1'b1);
    @(posedge clk); #1 valid = 1'b0;

    // back-to-back multiplies
    @(posedge clk); #1 funct = F_MULT; a = 32'd2; b = 32'd4; valid = 1'b1;
    hold_until_unstalled(F_MULT, 32'd6, 32'd7, n);
    check("b2b_wait", n, LAT_2X4); check("b2b_first_lo", o_lo, 32'd8); check("b2b_done", o_done, 1'b1);
    wait_done(n);
    check("b2b_lat", n, LAT_6X7); check("b2b_lo", o_lo, 32'd42); check("b2b_hi", o_hi, 32'd0);

    // mthi / mtlo / mfhi
    @(posedge clk); #1 funct = F_MTHI; a = 32'hAAAA0000; valid = 1'b1;
    @(posedge clk); #1 funct = F_MTLO; a = 32'h00005555;
    @(posedge clk); #1 valid = 1'b0; funct = F_MFHI;
    @(negedge clk);
    check("mthi", o_hi, 32'hAAAA0000); check("mtlo", o_lo, 32'h00005555);
    check("mfhi", o_mf_dato, 32'hAAAA0000); check("mt_no_done", o_done, 1'b0);

    // flush in cycle 10
    @(posedge clk); #1 funct = F_MULT; a = 32'd9; b = 32'h80000001; valid = 1'b1;
    repeat (10) begin @(posedge clk); #1 valid = 1'b0; end
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_busy", o_busy, 1'b0);
    check("flush_hi", o_hi, 32'hAAAA0000); check("flush_lo", o_lo, 32'h00005555);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= o_done; end
    check("flush_no_done", seen, 1'b0);

    // asynchronous reset mid-RUN
    @(posedge clk); #1 funct = F_MULTU; a = 32'd3; b = 32'h80000001; valid = 1'b1;
    repeat (5) begin @(posedge clk); #1 valid = 1'b0; end
    rst_n = 1'b0; funct = '0;
    #1;
    check("arst_busy", o_busy, 0); check("arst_done", o_done, 0); check("arst_hi", o_hi, 0);
    check("arst_lo", o_lo, 0); check("arst_mf", o_mf_dato, 0); check("arst_stall", o_stall, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    do_op(F_DIVU, 32'd100, 32'd7, lat);
    check("post_rst_lo", o_lo, 32'd14); check("post_rst_hi", o_hi, 32'd2);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
